// File: rtl/vga_tile_grid_if.sv
// ============================================================================
// Module  : vga_tile_grid_if
// Brief   : Pixel, cell-write and clear signals of the tile-grid renderer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface vga_tile_grid_if #(
  parameter int CW = 3,
  parameter int RW = 3
);
  logic [9:0]    x;
  logic [9:0]    y;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_col;
  logic [RW-1:0] wr_row;
  logic [23:0]   wr_rgb;
  logic          clr_req;
  logic          clr_busy;
  logic [7:0]    r_out;
  logic [7:0]    g_out;
  logic [7:0]    b_out;
`ifdef GRID_CURSOR_EN
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
`endif

  modport master (
    output x, y, wr_valid, wr_col, wr_row, wr_rgb, clr_req,
`ifdef GRID_CURSOR_EN
    output cursor_col, cursor_row,
`endif
    input  wr_ready, clr_busy, r_out, g_out, b_out
  );

  modport slave (
    input  x, y, wr_valid, wr_col, wr_row, wr_rgb, clr_req,
`ifdef GRID_CURSOR_EN
    input  cursor_col, cursor_row,
`endif
    output wr_ready, clr_busy, r_out, g_out, b_out
  );
endinterface

`default_nettype wire

// File: rtl/vga_tile_grid.sv
// ============================================================================
// Module  : vga_tile_grid
// Brief   : COLS x ROWS tile renderer, 2-cycle pixel pipeline, write port and
//           sweep-clear FSM. Define GRID_CURSOR_EN for the cursor border.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vga_tile_grid #(
  parameter int          COLS    = 8,
  parameter int          ROWS    = 8,
  parameter int          TILE    = 60,
  parameter int          GAP     = 1,
  parameter int          X0      = 80,
  parameter int          Y0      = 0,
  parameter logic [23:0] BG_RGB  = 24'hD9D9D6,
  parameter logic [23:0] GAP_RGB = 24'h000000,
  parameter logic [23:0] CLR_RGB = 24'h53565B,
  parameter logic [23:0] CUR_RGB = 24'hFFFF00
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  vga_tile_grid_if.slave bus
);

  localparam int PITCH  = TILE + GAP;
  localparam int CELLS  = COLS * ROWS;
  localparam int AW     = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int GRID_W = COLS * PITCH;
  localparam int GRID_H = ROWS * PITCH;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic          wr_ready_q;
  logic          clr_busy_q;

  logic [23:0]   cell_mem [CELLS];

  // ---------------- stage 1: region decode ----------------
  logic [31:0]   x_ext, y_ext, dx, dy, col_full, row_full, mod_x, mod_y;
  logic          in_grid;
  logic          s1_vld_d, s1_grid_d, s1_tile_d;
  logic [AW-1:0] s1_addr_d;
  logic          s1_vld_q, s1_grid_q, s1_tile_q;
  logic [AW-1:0] s1_addr_q;
  logic          s1_cur_d, s1_cur_q;

  always_comb begin
    x_ext    = {22'd0, bus.x};
    y_ext    = {22'd0, bus.y};
    dx       = x_ext - 32'(X0);
    dy       = y_ext - 32'(Y0);
    col_full = dx / 32'(PITCH);
    row_full = dy / 32'(PITCH);
    mod_x    = dx % 32'(PITCH);
    mod_y    = dy % 32'(PITCH);
    in_grid  = (x_ext >= 32'(X0)) && (x_ext < 32'(X0 + GRID_W)) &&
               (y_ext >= 32'(Y0)) && (y_ext < 32'(Y0 + GRID_H));
    s1_vld_d  = 1'b1;
    s1_grid_d = in_grid;
    s1_tile_d = in_grid && (mod_x < 32'(TILE)) && (mod_y < 32'(TILE));
    s1_addr_d = in_grid ? AW'(row_full * 32'(COLS) + col_full) : '0;
`ifdef GRID_CURSOR_EN
    // Border band is 2 px thick on every side of the cursor tile.
    s1_cur_d  = (col_full == 32'(bus.cursor_col)) &&
                (row_full == 32'(bus.cursor_row)) &&
                ((mod_x < 32'd2) || (mod_x >= 32'(TILE - 2)) ||
                 (mod_y < 32'd2) || (mod_y >= 32'(TILE - 2)));
`else
    s1_cur_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_grid_q <= 1'b0;
      s1_tile_q <= 1'b0;
      s1_addr_q <= '0;
      s1_cur_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_grid_q <= s1_grid_d;
      s1_tile_q <= s1_tile_d;
      s1_addr_q <= s1_addr_d;
      s1_cur_q  <= s1_cur_d;
    end
  end

  // ---------------- stage 2: colour select ----------------
  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = 24'h000000;
    if (s1_vld_q) begin
      if (s1_tile_q)      rgb_d = s1_cur_q ? CUR_RGB : cell_mem[s1_addr_q];
      else if (s1_grid_q) rgb_d = GAP_RGB;
      else                rgb_d = BG_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rgb_q <= 24'h000000;
    else        rgb_q <= rgb_d;
  end

  // ---------------- cell RAM write port ----------------
  logic          wr_in_range;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [23:0]   mem_wdata;

  always_comb begin
    wr_in_range = (32'(bus.wr_col) < 32'(COLS)) && (32'(bus.wr_row) < 32'(ROWS));
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = CLR_RGB;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
    end else if (bus.wr_valid && wr_ready_q && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = AW'(32'(bus.wr_row) * 32'(COLS) + 32'(bus.wr_col));
      mem_wdata = bus.wr_rgb;
    end
  end

  // Combinational read above samples the old word on the write edge (read-first).
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) cell_mem[mem_waddr] <= mem_wdata;
  end

  // ---------------- sweep-clear FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      idx_q      <= '0;
      wr_ready_q <= 1'b0;
      clr_busy_q <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (idx_q == AW'(CELLS - 1)) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wr_ready_q <= 1'b1;
            clr_busy_q <= 1'b0;
          end else begin
            idx_q      <= idx_q + AW'(1);
          end
        end
        S_IDLE: begin
          if (bus.clr_req) begin
            state_q    <= S_CLEAR;
            idx_q      <= '0;
            wr_ready_q <= 1'b0;
            clr_busy_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_CLEAR;
          idx_q      <= '0;
          wr_ready_q <= 1'b0;
          clr_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.clr_busy = clr_busy_q;
  assign bus.r_out    = rgb_q[23:16];
  assign bus.g_out    = rgb_q[15:8];
  assign bus.b_out    = rgb_q[7:0];

endmodule

`default_nettype wire
